uart_rx_core: RTL and testbench

Parametrised UART receiver for the 50 MHz fabric, replacing the fixed-rate receiver. It adds:
- 16x oversampled mid-bit sampling with an input synchroniser and start-bit glitch rejection.
- Configurable data width, parity and stop bits.
- Parity, framing and overrun detection.
- A valid/ready output handshake towards the command decoder or RX FIFO.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_rx_core.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared parity encodings, receiver FSM states and the baud divisor helper.
// Contents:
//    PAR_NONE / PAR_ODD / PAR_EVEN  values accepted by the PARITY parameter
//    rx_state_t                     receiver FSM state encoding
//    calc_div()                     clocks per oversample tick, integer-truncated
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } rx_state_t;

   function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
      return clk_freq / (baud * oversample);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator, one-cycle tick every DIV clocks.
// Ports:
//    clk_50  in   system clock
//    rst_n   in   synchronous active-low reset, clears the divider
//    tick    out  high for one cycle when the divider wraps (every DIV clocks)
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic clk_50,
   input  logic rst_n,
   output logic tick
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int W   = (DIV < 2) ? 1 : $clog2(DIV);

   if (DIV < 2) begin : g_bad_div
      $error("uart_baud_tick: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
   end

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(DIV - 1));

   always_ff @(posedge clk_50) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= tick ? '0 : cnt + W'(1);
   end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampled UART receiver with parity/framing/overrun detection and valid/ready output.
// Ports:
//    clk_50       in   system clock, single domain
//    rst_n        in   synchronous active-low reset
//    uart_rx      in   asynchronous serial line, idle high
//    data_out     out  received payload, LSB received first
//    data_valid   out  data_out holds an unconsumed word
//    data_ready   in   consumer takes the word when data_valid && data_ready
//    parity_err   out  one-cycle pulse with a delivered word whose parity mismatched
//    frame_err    out  one-cycle pulse when a stop bit samples 0
//    overrun_err  out  one-cycle pulse when a completed word is dropped
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = PAR_NONE,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk_50,
   input  logic                 rst_n,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err
);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_core: DATA_BITS must be 5..9");
   end
   if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
      $error("uart_rx_core: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_rx_core: STOP_BITS must be 1 or 2");
   end

   logic                 tick;
   logic [1:0]           sync;
   logic                 rx_s;
   rx_state_t            state, state_n;
   logic [3:0]           os_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bad;
   logic                 mid, bit_end;
   logic                 os_clr, bit_clr, bit_inc, shift_en, par_en, done, ferr;
   logic                 accept;

   uart_baud_tick #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .OVERSAMPLE(16)
   ) u_tick (
      .clk_50(clk_50),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign rx_s    = sync[1];
   assign mid     = tick && (os_cnt == 4'd7);
   assign bit_end = tick && (os_cnt == 4'd15);
   assign accept  = !data_valid || data_ready;

   always_ff @(posedge clk_50) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   // START re-centres os_cnt at mid-bit, so every later os_cnt==15 lands mid-bit too.
   // bit_cnt is reused as the stop-bit counter once the payload is in.
   always_comb begin
      state_n  = state;
      os_clr   = 1'b0;
      bit_clr  = 1'b0;
      bit_inc  = 1'b0;
      shift_en = 1'b0;
      par_en   = 1'b0;
      done     = 1'b0;
      ferr     = 1'b0;
      case (state)
         S_IDLE: if (tick && !rx_s) begin
            os_clr  = 1'b1;
            state_n = S_START;
         end
         S_START: if (mid) begin
            if (rx_s) state_n = S_IDLE;
            else begin
               os_clr  = 1'b1;
               bit_clr = 1'b1;
               state_n = S_DATA;
            end
         end
         S_DATA: if (bit_end) begin
            shift_en = 1'b1;
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
               bit_clr = 1'b1;
               state_n = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            end else bit_inc = 1'b1;
         end
         S_PARITY: if (bit_end) begin
            par_en  = 1'b1;
            state_n = S_STOP;
         end
         S_STOP: if (bit_end) begin
            if (!rx_s) begin
               ferr    = 1'b1;
               state_n = S_WAIT_HIGH;
            end else if (bit_cnt == 4'(STOP_BITS - 1)) begin
               done    = 1'b1;
               state_n = S_IDLE;
            end else bit_inc = 1'b1;
         end
         S_WAIT_HIGH: if (rx_s) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Payload shifts in from the top so the first-received bit ends at the LSB.
   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         sync    <= 2'b11;
         os_cnt  <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bad <= 1'b0;
      end else begin
         sync    <= {sync[0], uart_rx};
         os_cnt  <= os_clr ? 4'd0 : os_cnt + (tick ? 4'd1 : 4'd0);
         bit_cnt <= bit_clr ? 4'd0 : bit_cnt + (bit_inc ? 4'd1 : 4'd0);
         if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         if (os_clr)      par_bad <= 1'b0;
         else if (par_en) par_bad <= rx_s != ((^shreg) ^ (PARITY == PAR_ODD));
      end
   end

   // A completed word loads only if the slot is free or being emptied this edge; otherwise it is dropped.
   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         data_out    <= '0;
         data_valid  <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         parity_err  <= done && accept && par_bad;
         frame_err   <= ferr;
         overrun_err <= done && !accept;
         if (done && accept) begin
            data_out   <= shreg;
            data_valid <= 1'b1;
         end else if (data_valid && data_ready) data_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: self-checking bench driving three receiver configurations (8N1, 7E1, 9N2) at 115200 baud.
module tb_uart_rx_core;

   localparam int CF = 50_000_000;
   localparam int BR = 115200;
   localparam int DV = CF / (BR * 16);
   localparam int BT = 16 * DV;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx    [3];
   logic       ready [3];
   logic       dv    [3];
   logic       pe    [3];
   logic       fe    [3];
   logic       oe    [3];
   logic [7:0] d0;
   logic [6:0] d1;
   logic [8:0] d2;
   logic [8:0] dout  [3];

   int cyc = 0;
   int npe [3] = '{0, 0, 0};
   int nfe [3] = '{0, 0, 0};
   int noe [3] = '{0, 0, 0};
   int nld [3] = '{0, 0, 0};
   int rise[3] = '{0, 0, 0};
   logic dvp[3];

   logic       exp_v[3];
   logic [8:0] exp_d[3];
   int e_pe[3] = '{0, 0, 0};
   int e_fe[3] = '{0, 0, 0};
   int e_oe[3] = '{0, 0, 0};
   int e_ld[3] = '{0, 0, 0};
   int ntests = 0;
   int nfail  = 0;

   uart_rx_core #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk_50(clk), .rst_n(rst_n), .uart_rx(rx[0]), .data_out(d0), .data_valid(dv[0]),
      .data_ready(ready[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun_err(oe[0]));
   uart_rx_core #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
      .clk_50(clk), .rst_n(rst_n), .uart_rx(rx[1]), .data_out(d1), .data_valid(dv[1]),
      .data_ready(ready[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun_err(oe[1]));
   uart_rx_core #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u2 (
      .clk_50(clk), .rst_n(rst_n), .uart_rx(rx[2]), .data_out(d2), .data_valid(dv[2]),
      .data_ready(ready[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun_err(oe[2]));

   always #10 clk = ~clk;

   always_comb begin
      dout[0] = {1'b0, d0};
      dout[1] = {2'b0, d1};
      dout[2] = d2;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse counters count high cycles, so a pulse wider than one cycle shows up as an extra count.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (pe[i] === 1'b1) npe[i] <= npe[i] + 1;
         if (fe[i] === 1'b1) nfe[i] <= nfe[i] + 1;
         if (oe[i] === 1'b1) noe[i] <= noe[i] + 1;
         if (dv[i] === 1'b1 && dvp[i] !== 1'b1) begin
            nld[i]  <= nld[i] + 1;
            rise[i] <= cyc;
         end
         dvp[i] <= dv[i];
      end
   end

   function automatic int nb(input int ch);
      return (ch == 0) ? 8 : (ch == 1) ? 7 : 9;
   endfunction

   function automatic int par(input int ch);
      return (ch == 1) ? 2 : 0;
   endfunction

   function automatic int sb(input int ch);
      return (ch == 2) ? 2 : 1;
   endfunction

   function automatic int nbits(input int ch);
      return 1 + nb(ch) + ((par(ch) != 0) ? 1 : 0) + sb(ch);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transmit-side encoder: start, payload LSB first, optional parity, stop bits; truncated to limit bits.
   task automatic send(input int ch, input logic [8:0] d, input bit bad_par, input bit bad_stop,
                       input int limit, output int t0);
      logic b[16];
      logic p;
      int   n;
      for (int i = 0; i < 16; i++) b[i] = 1'b1;
      b[0] = 1'b0;
      p = (par(ch) == 1);
      for (int i = 0; i < nb(ch); i++) begin
         b[1 + i] = d[i];
         p = p ^ d[i];
      end
      n = 1 + nb(ch);
      if (par(ch) != 0) begin
         b[n] = p ^ bad_par;
         n++;
      end
      if (bad_stop) b[n] = 1'b0;
      n = n + sb(ch);
      if (limit < n) n = limit;
      t0 = cyc;
      for (int i = 0; i < n; i++) begin
         rx[ch] = b[i];
         repeat (BT) @(negedge clk);
      end
      rx[ch] = 1'b1;
   endtask

   task automatic model(input int ch, input logic [8:0] d, input bit bad_par, input bit bad_stop,
                        output bit loaded);
      loaded = 1'b0;
      if (bad_stop) e_fe[ch]++;
      else if (!exp_v[ch] || ready[ch]) begin
         exp_v[ch] = 1'b1;
         exp_d[ch] = d & 9'((1 << nb(ch)) - 1);
         e_ld[ch]++;
         if (bad_par) e_pe[ch]++;
         loaded = 1'b1;
      end else e_oe[ch]++;
   endtask

   task automatic check(input int ch, input string tag);
      chk($sformatf("%s.u%0d.valid", tag, ch), dv[ch], exp_v[ch]);
      chk($sformatf("%s.u%0d.data", tag, ch), dout[ch], exp_d[ch]);
      chk($sformatf("%s.u%0d.parity_err", tag, ch), npe[ch], e_pe[ch]);
      chk($sformatf("%s.u%0d.frame_err", tag, ch), nfe[ch], e_fe[ch]);
      chk($sformatf("%s.u%0d.overrun_err", tag, ch), noe[ch], e_oe[ch]);
      chk($sformatf("%s.u%0d.loads", tag, ch), nld[ch], e_ld[ch]);
   endtask

   // Valid rises one edge after the mid-stop sample: 2 sync clocks + up to one tick of detection phase.
   task automatic check_lat(input int ch, input int t0, input string tag);
      int d;
      d = rise[ch] - t0 - (8 + 16 * (nbits(ch) - 1)) * DV;
      chk($sformatf("%s.u%0d.latency_in_window(off=%0d)", tag, ch, d), (d >= 2 && d <= DV + 3), 1);
   endtask

   task automatic consume(input int ch);
      ready[ch] = 1'b1;
      @(negedge clk);
      ready[ch] = 1'b0;
      exp_v[ch] = 1'b0;
      chk($sformatf("consume.u%0d.valid", ch), dv[ch], exp_v[ch]);
   endtask

   initial begin
      int t;
      bit ld;
      int ts[3];
      logic [8:0] rd[3];
      bit bp[3];
      bit bs[3];
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rx[i]    = 1'b1;
         ready[i] = 1'b0;
         exp_v[i] = 1'b0;
         exp_d[i] = '0;
      end
      repeat (4) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check(i, "reset");
         chk($sformatf("reset.u%0d.flags", i), {pe[i], fe[i], oe[i]}, 3'b000);
      end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      send(0, 9'h0A5, 0, 0, 99, t);
      model(0, 9'h0A5, 0, 0, ld);
      check(0, "a5");
      check_lat(0, t, "a5");
      repeat (200) @(negedge clk);
      chk("a5.hold_valid", dv[0], 1'b1);
      consume(0);

      rx[0] = 1'b0;
      repeat (4 * DV) @(negedge clk);
      rx[0] = 1'b1;
      repeat (2 * BT) @(negedge clk);
      check(0, "glitch");
      send(0, 9'h03C, 0, 0, 99, t);
      model(0, 9'h03C, 0, 0, ld);
      check(0, "after_glitch");
      check_lat(0, t, "after_glitch");
      consume(0);

      send(0, 9'h055, 0, 1, 99, t);
      rx[0] = 1'b0;
      model(0, 9'h055, 0, 1, ld);
      repeat (30 * BT) @(negedge clk);
      check(0, "break");
      rx[0] = 1'b1;
      repeat (BT) @(negedge clk);
      send(0, 9'h055, 0, 0, 99, t);
      model(0, 9'h055, 0, 0, ld);
      check(0, "after_break");
      check_lat(0, t, "after_break");
      consume(0);

      send(0, 9'h011, 0, 0, 99, t);
      model(0, 9'h011, 0, 0, ld);
      check(0, "first_11");
      check_lat(0, t, "first_11");
      send(0, 9'h022, 0, 0, 99, t);
      model(0, 9'h022, 0, 0, ld);
      check(0, "overrun_22");
      consume(0);

      send(1, 9'h03C, 1, 0, 99, t);
      model(1, 9'h03C, 1, 0, ld);
      check(1, "parity_3c");
      check_lat(1, t, "parity_3c");
      consume(1);

      send(2, 9'h1FF, 0, 0, 99, t);
      model(2, 9'h1FF, 0, 0, ld);
      check(2, "w9_1ff");
      check_lat(2, t, "w9_1ff");
      send(2, 9'h0B4, 0, 0, 5, t);
      rst_n = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         exp_v[i] = 1'b0;
         exp_d[i] = '0;
         check(i, "mid_rst");
      end
      rst_n = 1'b1;
      repeat (12 * BT) @(negedge clk);
      check(2, "post_rst_idle");
      send(2, 9'h0A3, 0, 0, 99, t);
      model(2, 9'h0A3, 0, 0, ld);
      check(2, "post_rst_frame");
      check_lat(2, t, "post_rst_frame");
      consume(2);

      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 3; i++) begin
            if (exp_v[i] && $urandom_range(0, 1) == 1) consume(i);
            rd[i] = 9'($urandom);
            bp[i] = (i == 1) && ($urandom_range(0, 1) == 1);
            bs[i] = ($urandom_range(0, 3) == 0);
         end
         fork
            send(0, rd[0], bp[0], bs[0], 99, ts[0]);
            send(1, rd[1], bp[1], bs[1], 99, ts[1]);
            send(2, rd[2], bp[2], bs[2], 99, ts[2]);
         join
         for (int i = 0; i < 3; i++) begin
            model(i, rd[i], bp[i], bs[i], ld);
            check(i, $sformatf("rand%0d", r));
            if (ld) check_lat(i, ts[i], $sformatf("rand%0d", r));
         end
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
